// File: rtl/pmem_pkg.sv
// Shared constants and state type for the physical-memory burst interface.
// Used by the cacheline adaptor, the LLC and the testbench.
package pmem_pkg;

    localparam int unsigned LINE_W      = 256;
    localparam int unsigned BURST_W     = 64;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned BEATS       = LINE_W / BURST_W;
    localparam int unsigned OFFSET_BITS = $clog2(LINE_W / 8);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } adaptor_state_e;

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts one LLC cacheline read/write into a 4-beat burst on the memory
// interface and reassembles read beats into a full line.
module cacheline_adaptor #(
    parameter int unsigned LINE_W  = pmem_pkg::LINE_W,
    parameter int unsigned BURST_W = pmem_pkg::BURST_W,
    parameter int unsigned ADDR_W  = pmem_pkg::ADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic               read_i,
    input  logic               write_i,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    output logic               resp_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o,
    output logic [BURST_W-1:0] burst_o,
    input  logic [BURST_W-1:0] burst_i,
    input  logic               resp_i
);
    import pmem_pkg::*;

    localparam int unsigned NBEATS = LINE_W / BURST_W;
    localparam int unsigned CW     = $clog2(NBEATS);
    localparam int unsigned OFFS   = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((64'd1 << OFFS) - 64'd1);

    adaptor_state_e     state_q, state_d;
    logic [CW-1:0]      count_q, count_nx;
    logic [ADDR_W-1:0]  addr_q;
    logic [BURST_W-1:0] burst_q;
    logic [BURST_W-1:0] lbuf_q [NBEATS];
    logic [BURST_W-1:0] wbuf_q [NBEATS];
    logic               last_beat;

    assign count_nx  = count_q + 1'b1;
    assign last_beat = resp_i && (count_q == CW'(NBEATS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        read_o  = 1'b0;
        write_o = 1'b0;
        resp_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (read_i) begin
                    state_d = RD;
                end else if (write_i) begin
                    state_d = WR;
                end
            end
            RD: begin
                read_o = 1'b1;
                if (last_beat) begin
                    state_d = DONE;
                end
            end
            WR: begin
                write_o = 1'b1;
                if (last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                resp_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // burst_o is preloaded with beat 0 on accept and steps to the next slot on
    // each accepted beat, so it never depends combinationally on resp_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            addr_q  <= '0;
            burst_q <= '0;
            for (int unsigned i = 0; i < NBEATS; i++) begin
                lbuf_q[i] <= '0;
                wbuf_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (read_i) begin
                        addr_q  <= address_i & ALIGN_MASK;
                        count_q <= '0;
                    end else if (write_i) begin
                        addr_q  <= address_i & ALIGN_MASK;
                        count_q <= '0;
                        burst_q <= line_i[BURST_W-1:0];
                        for (int unsigned i = 0; i < NBEATS; i++) begin
                            wbuf_q[i] <= line_i[i*BURST_W +: BURST_W];
                        end
                    end
                end
                RD: begin
                    if (resp_i) begin
                        lbuf_q[count_q] <= burst_i;
                        count_q         <= count_nx;
                    end
                end
                WR: begin
                    if (resp_i) begin
                        burst_q <= wbuf_q[count_nx];
                        count_q <= count_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        line_o = '0;
        for (int unsigned i = 0; i < NBEATS; i++) begin
            line_o[i*BURST_W +: BURST_W] = lbuf_q[i];
        end
    end

    assign address_o = addr_q;
    assign burst_o   = burst_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed + randomized bench for cacheline_adaptor against a line-level
// shadow memory model.
module tb_cacheline_adaptor;
    import pmem_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       address_i;
    logic              read_i, write_i;
    logic [255:0]      line_i, line_o;
    logic              resp_o;
    logic [31:0]       address_o;
    logic              read_o, write_o;
    logic [63:0]       burst_o, burst_i;
    logic              resp_i;

    int total = 0;
    int bad   = 0;

    // Line-granular shadow memory plus what the outputs should be holding.
    logic [255:0] shadow [logic [31:0]];
    logic [255:0] last_rd;
    logic [255:0] last_wr;
    logic [31:0]  last_al;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .line_i    (line_i),
        .line_o    (line_o),
        .resp_o    (resp_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .burst_o   (burst_o),
        .burst_i   (burst_i),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h required=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    // One LLC transaction. pat bit c says whether memory strobes in beat cycle c
    // (cycles past plen strobe every cycle); plen==0 means random gaps.
    task automatic txn(input bit is_rd, input bit both, input logic [31:0] a,
                       input logic [255:0] wl, input int lat,
                       input logic [31:0] pat, input int plen);
        logic [255:0] exp_line;
        logic [31:0]  al;
        logic [1:0]   req;
        int k, cyc;
        bit r;
        al  = {a[31:5], 5'd0};
        req = is_rd ? 2'b10 : 2'b01;
        if (is_rd) begin
            if (!shadow.exists(al)) shadow[al] = rand_line();
            exp_line = shadow[al];
        end else begin
            exp_line = wl;
        end
        read_i    = is_rd;
        write_i   = !is_rd || both;
        address_i = a;
        line_i    = wl;
        @(posedge clk); #1;
        chk("req_first", {read_o, write_o}, req);
        chk("addr_aligned", address_o, al);
        chk("resp_early", resp_o, 0);
        repeat (lat) begin
            resp_i  = 1'b0;
            burst_i = {$urandom, $urandom};
            @(posedge clk); #1;
            chk("req_latency", {read_o, write_o}, req);
            chk("resp_latency", resp_o, 0);
        end
        k = 0;
        cyc = 0;
        while (k < 4 && cyc < 64) begin
            if (plen == 0)      r = ($urandom_range(0, 2) != 0);
            else if (cyc < plen) r = pat[cyc];
            else                r = 1'b1;
            resp_i  = r;
            burst_i = r && is_rd ? exp_line[64*k +: 64] : {$urandom, $urandom};
            if (!is_rd) chk("burst_beat", burst_o, exp_line[64*k +: 64]);
            else        chk("burst_hold_rd", burst_o, last_wr[63:0]);
            @(posedge clk); #1;
            if (r) k++;
            cyc++;
            if (k < 4) begin
                chk("req_burst", {read_o, write_o}, req);
                chk("resp_burst", resp_o, 0);
            end
        end
        resp_i = 1'b0;
        chk("beat_budget", k, 4);
        chk("resp_pulse", resp_o, 1);
        chk("req_done", {read_o, write_o}, 2'b00);
        chk("addr_done", address_o, al);
        if (is_rd) last_rd = exp_line;
        else begin
            shadow[al] = wl;
            last_wr    = wl;
        end
        last_al = al;
        chk("line_done", line_o, last_rd);
        read_i  = 1'b0;
        write_i = 1'b0;
        @(posedge clk); #1;
        chk("resp_single", resp_o, 0);
        chk("req_idle", {read_o, write_o}, 2'b00);
    endtask

    initial begin
        logic [255:0] l;
        rst_n     = 1'b0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        line_i    = '0;
        burst_i   = '0;
        resp_i    = 1'b0;
        last_rd   = '0;
        last_wr   = '0;
        last_al   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {read_o, write_o, resp_o}, 3'b000);
        chk("rst_addr", address_o, 0);
        chk("rst_burst", burst_o, 0);
        chk("rst_line", line_o, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // read wins over write; write buffer (seen via burst_o) stays zero
        txn(1'b1, 1'b1, 32'h0000_0500, rand_line(), 1, 32'hFFFF_FFFF, 32);

        // aligned read with fixed beats
        l = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        shadow[32'h0000_1040] = l;
        txn(1'b1, 1'b0, 32'h0000_1040, '0, 2, 32'hFFFF_FFFF, 32);
        chk("aligned_line", line_o, l);

        // unaligned write
        l = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        txn(1'b0, 1'b0, 32'h0000_205C, l, 0, 32'hFFFF_FFFF, 32);
        chk("write_addr", last_al, 32'h0000_2040);

        // stalled read: strobes 1,0,0,1,1,0,1
        txn(1'b1, 1'b0, 32'h0000_3080, '0, 0, 32'b1011001, 7);

        // reset after two read beats
        read_i    = 1'b1;
        address_i = 32'h0000_4000;
        @(posedge clk); #1;
        repeat (2) begin
            resp_i  = 1'b1;
            burst_i = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        resp_i = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("midrst_req", {read_o, write_o, resp_o}, 3'b000);
        chk("midrst_addr", address_o, 0);
        chk("midrst_burst", burst_o, 0);
        chk("midrst_line", line_o, 0);
        read_i = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("midrst_noresp", resp_o, 0);
        end
        rst_n   = 1'b1;
        last_rd = '0;
        last_wr = '0;
        last_al = '0;
        @(posedge clk); #1;
        chk("postrst_noresp", resp_o, 0);
        txn(1'b1, 1'b0, 32'h0000_4000, '0, 1, 32'hFFFF_FFFF, 32);

        // spurious strobes in IDLE
        repeat (3) begin
            resp_i  = 1'b1;
            burst_i = {$urandom, $urandom};
            @(posedge clk); #1;
            chk("idle_strobe_req", {read_o, write_o, resp_o}, 3'b000);
            chk("idle_strobe_line", line_o, last_rd);
            chk("idle_strobe_addr", address_o, last_al);
            chk("idle_strobe_burst", burst_o, last_wr[63:0]);
        end
        resp_i = 1'b0;

        // back-to-back read then write, then read back the written line
        txn(1'b1, 1'b0, 32'h0000_5020, '0, 1, 0, 0);
        txn(1'b0, 1'b0, 32'h0000_6011, rand_line(), 2, 0, 0);
        txn(1'b1, 1'b0, 32'h0000_6000, '0, 0, 0, 0);

        // randomized traffic over a small address set so lines get reused
        for (int n = 0; n < 12; n++) begin
            logic [31:0] a;
            a = {24'h0000_70, 8'h00} | ($urandom_range(0, 3) << 5) | $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1)
                txn(1'b1, 1'b0, a, '0, $urandom_range(0, 3), 0, 0);
            else
                txn(1'b0, 1'b0, a, rand_line(), $urandom_range(0, 3), 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
